// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter.
// Shares the single register-file write port between WB writeback, the
// exception EPC save into $k0 and bytes received by the UART. The write port is
// purely combinational so WB timing is unchanged. UART bytes wait in a small
// FIFO. One EPC save is held pending while stall_req freezes the front end.
//
// EPC FSM states:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no EPC save outstanding; exc_req latches the EPC
//   EXC_PEND | EPC latched, waiting for the port; leaves on the $k0 write
module regfile_wport_arbiter #(
    parameter int         DEPTH     = 4,
    parameter logic [4:0] UART_REG0 = 5'd4,
    parameter logic [4:0] UART_REG1 = 5'd5,
    parameter logic [4:0] KREG      = 5'd26
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_we,
    input  logic [4:0]                wb_addr,
    input  logic [31:0]               wb_data,
    input  logic                      exc_req,
    input  logic [31:0]               exc_epc,
    input  logic                      uart_signal,
    input  logic                      uart_flag,
    input  logic [7:0]                uart_rx_data,
    input  logic                      ovf_clr,
    output logic                      reg_we,
    output logic [4:0]                reg_waddr,
    output logic [31:0]               reg_wdata,
    output logic [1:0]                grant,
    output logic                      stall_req,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      uart_overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_WB   = 2'b01;
    localparam logic [1:0] GNT_EXC  = 2'b10;
    localparam logic [1:0] GNT_UART = 2'b11;

    typedef enum logic {
        IDLE     = 1'b0,
        EXC_PEND = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          epc_load;
    logic [31:0]   epc_q;

    // FIFO entry is {flag, byte}; pointers carry one extra wrap bit.
    logic [8:0]    fifo_mem [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic [AW:0]   level;
    logic [8:0]    head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          drop;
    logic          ovf_q;

    assign level      = wptr_q - rptr_q;
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head       = fifo_mem[rptr_q[AW-1:0]];

    // Fixed-priority write-port mux: WB, then pending EPC save, then UART head.
    // Everything is held at zero while reset is asserted.
    always_comb begin
        grant     = GNT_NONE;
        reg_we    = 1'b0;
        reg_waddr = 5'd0;
        reg_wdata = 32'd0;
        if (rst_n) begin
            if (wb_we) begin
                grant     = GNT_WB;
                reg_we    = 1'b1;
                reg_waddr = wb_addr;
                reg_wdata = wb_data;
            end else if (state_q == EXC_PEND) begin
                grant     = GNT_EXC;
                reg_we    = 1'b1;
                reg_waddr = KREG;
                reg_wdata = epc_q;
            end else if (!fifo_empty) begin
                grant     = GNT_UART;
                reg_we    = 1'b1;
                reg_waddr = head[8] ? UART_REG1 : UART_REG0;
                reg_wdata = {24'd0, head[7:0]};
            end
        end
    end

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign pop  = (grant == GNT_UART);
    assign push = uart_signal & (~fifo_full | pop);
    assign drop = uart_signal & fifo_full & ~pop;

    // EPC FSM next state; a new exc_req while a save is pending is ignored.
    always_comb begin
        state_d  = state_q;
        epc_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (exc_req) begin
                    state_d  = EXC_PEND;
                    epc_load = 1'b1;
                end
            end
            EXC_PEND: begin
                if (grant == GNT_EXC) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EPC FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the EPC only when a save is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q <= 32'd0;
        end else if (epc_load) begin
            epc_q <= exc_epc;
        end
    end

    // FIFO pointers; reset empties the FIFO and discards buffered bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q[AW-1:0]] <= {uart_flag, uart_rx_data};
        end
    end

    // Sticky overflow flag; a new drop takes precedence over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign stall_req     = rst_n & (exc_req | (state_q == EXC_PEND));
    assign fifo_level    = rst_n ? level : '0;
    assign uart_overflow = rst_n & ovf_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Testbench for regfile_wport_arbiter: directed scenarios followed by random
// traffic, checked against a queue-based reference model through a scoreboard.
module tb_regfile_wport_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        exc_req = 1'b0;
    logic [31:0] exc_epc = '0;
    logic        uart_signal = 1'b0;
    logic        uart_flag = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        ovf_clr = 1'b0;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [1:0]  grant;
    logic        stall_req;
    logic [2:0]  fifo_level;
    logic        uart_overflow;

    regfile_wport_arbiter #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .exc_req       (exc_req),
        .exc_epc       (exc_epc),
        .uart_signal   (uart_signal),
        .uart_flag     (uart_flag),
        .uart_rx_data  (uart_rx_data),
        .ovf_clr       (ovf_clr),
        .reg_we        (reg_we),
        .reg_waddr     (reg_waddr),
        .reg_wdata     (reg_wdata),
        .grant         (grant),
        .stall_req     (stall_req),
        .fifo_level    (fifo_level),
        .uart_overflow (uart_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [1:0]  g;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [1:0]  g;
        logic        st;
        logic [2:0]  lvl;
        logic        ovf;
    } st_t;

    wr_t wq[$];
    st_t sq[$];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: pending EPC flag, UART byte queue, sticky overflow.
    bit          m_pend = 0;
    logic [31:0] m_epc = '0;
    logic [8:0]  m_q[$];
    bit          m_ovf = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Compute this cycle's expected response from the inputs just driven,
    // queue it, then advance the model to the next cycle.
    task automatic model_step();
        wr_t w;
        st_t s;
        int  gnt;
        bit  full;
        bit  popped;
        bit  dropped;
        s.cyc = cyc;
        if (!rst_n) begin
            m_pend = 0;
            m_epc  = '0;
            m_q.delete();
            m_ovf  = 0;
            s.g = 2'b00; s.st = 1'b0; s.lvl = 3'd0; s.ovf = 1'b0;
            sq.push_back(s);
            return;
        end
        s.st  = exc_req | m_pend;
        s.lvl = 3'(m_q.size());
        s.ovf = m_ovf;
        gnt = 0;
        w.a = '0;
        w.d = '0;
        if (wb_we) begin
            gnt = 1; w.a = wb_addr; w.d = wb_data;
        end else if (m_pend) begin
            gnt = 2; w.a = 5'd26; w.d = m_epc;
        end else if (m_q.size() > 0) begin
            gnt = 3;
            w.a = m_q[0][8] ? 5'd5 : 5'd4;
            w.d = {24'd0, m_q[0][7:0]};
        end
        s.g = 2'(gnt);
        if (gnt != 0) begin
            w.cyc = cyc;
            w.g   = 2'(gnt);
            wq.push_back(w);
        end
        full    = (m_q.size() == DEPTH);
        popped  = (gnt == 3);
        dropped = uart_signal && full && !popped;
        if (popped) void'(m_q.pop_front());
        if (uart_signal && !dropped) m_q.push_back({uart_flag, uart_rx_data});
        if (dropped) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        if (m_pend) begin
            if (gnt == 2) m_pend = 0;
        end else if (exc_req) begin
            m_pend = 1;
            m_epc  = exc_epc;
        end
        sq.push_back(s);
    endtask

    task automatic drv(input bit rn, input bit we, input logic [4:0] a, input logic [31:0] d,
                       input bit ex, input logic [31:0] ep,
                       input bit us, input bit uf, input logic [7:0] ub, input bit oc);
        @(posedge clk);
        #1;
        rst_n = rn; wb_we = we; wb_addr = a; wb_data = d;
        exc_req = ex; exc_epc = ep;
        uart_signal = us; uart_flag = uf; uart_rx_data = ub; ovf_clr = oc;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1, 0, 5'd0, 32'd0, 0, 32'd0, 0, 0, 8'd0, 0);
    endtask

    // Monitor: compare status every cycle and pop the write scoreboard on reg_we.
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("grant", 32'(grant), 32'(s.g));
                chk("stall_req", 32'(stall_req), 32'(s.st));
                chk("fifo_level", 32'(fifo_level), 32'(s.lvl));
                chk("uart_overflow", 32'(uart_overflow), 32'(s.ovf));
                chk("reg_we", 32'(reg_we), 32'(s.g != 2'b00));
                if (reg_we) begin
                    if (wq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_write cyc=%0d actual addr=%0d data=%0h required none",
                                 cyc, reg_waddr, reg_wdata);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
                        chk("wr_addr", 32'(reg_waddr), 32'(w.a));
                        chk("wr_data", reg_wdata, w.d);
                    end
                end else begin
                    chk("idle_addr", 32'(reg_waddr), 32'd0);
                    chk("idle_data", reg_wdata, 32'd0);
                end
            end
        end
    end

    initial begin
        // Reset holds every output low even with WB requesting.
        drv(0, 1, 5'd8, 32'hFFFF_FFFF, 1, 32'h1234, 1, 0, 8'h11, 0);
        drv(0, 1, 5'd8, 32'hFFFF_FFFF, 0, 32'h0, 0, 0, 8'h00, 0);
        idle(1);
        // Two bytes buffered behind WB, then reset mid-stream discards them.
        drv(1, 1, 5'd3, 32'h1, 0, 32'd0, 1, 0, 8'hAA, 0);
        drv(1, 1, 5'd3, 32'h2, 1, 32'h5555, 1, 1, 8'hBB, 0);
        drv(0, 0, 5'd0, 32'd0, 0, 32'd0, 0, 0, 8'd0, 0);
        idle(4);

        // Plain WB write passes straight through.
        drv(1, 1, 5'd8, 32'hDEAD_BEEF, 0, 32'd0, 0, 0, 8'd0, 0);
        drv(1, 1, 5'd0, 32'hCAFE_0000, 0, 32'd0, 0, 0, 8'd0, 0);
        idle(1);

        // Exception under WB; second exc_req is ignored.
        drv(1, 1, 5'd7, 32'h11, 1, 32'h0040_0010, 0, 0, 8'd0, 0);
        drv(1, 1, 5'd9, 32'h22, 1, 32'h0BAD_F00D, 0, 0, 8'd0, 0);
        idle(3);

        // UART ordering with WB idle.
        drv(1, 0, 5'd0, 32'd0, 0, 32'd0, 1, 0, 8'h12, 0);
        drv(1, 0, 5'd0, 32'd0, 0, 32'd0, 1, 1, 8'h34, 0);
        idle(3);

        // Overflow with WB holding the port.
        for (int i = 0; i < 5; i++)
            drv(1, 1, 5'd10, 32'(i), 0, 32'd0, 1, i[0], 8'h50 + 8'(i), 0);
        drv(1, 1, 5'd10, 32'h9, 0, 32'd0, 1, 0, 8'h5F, 1);
        drv(1, 0, 5'd0, 32'd0, 0, 32'd0, 1, 1, 8'h60, 0);
        drv(1, 1, 5'd11, 32'hA, 0, 32'd0, 0, 0, 8'd0, 1);
        idle(7);

        // Priority: WB, then EXC (overwriting a WB write to $k0), then UART.
        drv(1, 1, 5'd12, 32'hC, 0, 32'd0, 1, 0, 8'h77, 0);
        drv(1, 1, 5'd13, 32'hD, 1, 32'h8000_0180, 0, 0, 8'd0, 0);
        drv(1, 1, 5'd26, 32'hE, 0, 32'd0, 0, 0, 8'd0, 0);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 99) < 40),
                5'($urandom_range(0, 31)),
                $urandom(),
                ($urandom_range(0, 99) < 6),
                $urandom(),
                ($urandom_range(0, 99) < 35),
                1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 99) < 5));
        end
        idle(12);

        @(negedge clk);
        #1;
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
